// File: rtl/if_prefetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the
// decode-side valid/ready handshake and redirect inputs.
interface if_prefetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        br;
    logic [31:0] pc_branch;
    logic        except;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        id_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_out, pc_out,
        input  imem_ready, imem_rvalid, imem_rdata, br, pc_branch, except, id_ready
    );
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_out, pc_out,
        output imem_ready, imem_rvalid, imem_rdata, br, pc_branch, except, id_ready
    );
endinterface

// File: rtl/if_prefetch.sv
// Pipelined instruction prefetch with in-order queue, redirect flush and stale-response drop.
// Optional IF_PREFETCH_PERF_EN adds redirect / decode-starvation counters.
module if_prefetch #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0080
) (
    input  logic               clk,
    input  logic               rst,
    if_prefetch_if.master      bus
`ifdef IF_PREFETCH_PERF_EN
    ,
    output logic [31:0]        perf_redirects,
    output logic [31:0]        perf_starve
`endif
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW+1:0] DEPTH_W = (PW+2)'(DEPTH);
    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    logic [31:0] fpc_q, fpc_d;
    cnt_t        cnt_q, cnt_d, outst_q, outst_d, drop_q, drop_d;
    ptr_t        wr_q, wr_d, rd_q, rd_d, aw_q, aw_d, ar_q, ar_d;
    logic [31:0] data_q [DEPTH];
    logic [31:0] data_d [DEPTH];
    logic [31:0] pcm_q  [DEPTH];
    logic [31:0] pcm_d  [DEPTH];
    logic [31:0] pend_q [DEPTH];
    logic [31:0] pend_d [DEPTH];

    logic redirect, req, accept, valid, pop, resp, discard, push;
    logic [PW+1:0] occ;

    always_comb begin
        redirect = bus.except | bus.br;
        occ      = {1'b0, cnt_q} + {1'b0, outst_q};
        req      = !rst && !redirect && (occ < DEPTH_W);
        accept   = req && bus.imem_ready;
        valid    = (cnt_q != '0);
        pop      = valid && bus.id_ready;
        resp     = bus.imem_rvalid;
        discard  = resp && (drop_q != '0);
        push     = resp && !discard && !redirect;

        fpc_d   = fpc_q;
        cnt_d   = cnt_q;
        outst_d = cnt_t'(outst_q + cnt_t'(accept) - cnt_t'(resp));
        drop_d  = drop_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        aw_d    = aw_q;
        ar_d    = ar_q;
        data_d  = data_q;
        pcm_d   = pcm_q;
        pend_d  = pend_q;

        // Request addresses wait here until their response returns, dropped or not.
        if (accept) begin
            pend_d[aw_q] = fpc_q;
            aw_d         = ptr_t'(aw_q + 1'b1);
            fpc_d        = fpc_q + 32'd4;
        end
        if (resp)    ar_d   = ptr_t'(ar_q + 1'b1);
        if (discard) drop_d = cnt_t'(drop_q - 1'b1);
        if (pop)     rd_d   = ptr_t'(rd_q + 1'b1);
        if (push) begin
            data_d[wr_q] = bus.imem_rdata;
            pcm_d[wr_q]  = pend_q[ar_q];
            wr_d         = ptr_t'(wr_q + 1'b1);
        end
        cnt_d = cnt_t'(cnt_q + cnt_t'(push) - cnt_t'(pop));

        // Every response still in flight after this edge is stale; drops already
        // pending are a subset of outst, so they are not added again.
        if (redirect) begin
            fpc_d  = bus.except ? EXC_VECTOR : {bus.pc_branch[31:2], 2'b00};
            cnt_d  = '0;
            wr_d   = '0;
            rd_d   = '0;
            drop_d = cnt_t'(outst_q - cnt_t'(resp));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q   <= RESET_PC;
            cnt_q   <= '0;
            outst_q <= '0;
            drop_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            aw_q    <= '0;
            ar_q    <= '0;
        end else begin
            fpc_q   <= fpc_d;
            cnt_q   <= cnt_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            aw_q    <= aw_d;
            ar_q    <= ar_d;
        end
    end

    // Storage needs no reset: outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        pcm_q  <= pcm_d;
        pend_q <= pend_d;
    end

    assign bus.imem_req   = req;
    assign bus.imem_addr  = fpc_q;
    assign bus.inst_valid = valid;
    assign bus.inst_out   = valid ? data_q[rd_q] : 32'h0;
    assign bus.pc_out     = valid ? pcm_q[rd_q]  : 32'h0;

`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] red_q, red_d, starve_q, starve_d;

    always_comb begin
        red_d    = red_q + {31'h0, redirect};
        starve_d = starve_q + {31'h0, (!valid && bus.id_ready)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            red_q    <= '0;
            starve_q <= '0;
        end else begin
            red_q    <= red_d;
            starve_q <= starve_d;
        end
    end

    assign perf_redirects = red_q;
    assign perf_starve    = starve_q;
`endif
endmodule
